// File: rtl/dom_result_reader_if.sv
// DOM SRAM read port plus the 32-bit result stream, bundled for dom_result_reader.
// master = reader side, slave = SRAM/consumer side.
interface dom_result_reader_if #(
   parameter int OUTPUT_LENGTH = 8,
   parameter int DATA_WIDTH    = 32
);
   localparam int AW = $clog2(OUTPUT_LENGTH);

   logic [AW-1:0]         rdr__dom__address;
   logic                  rdr__dom__enable;
   logic                  rdr__dom__write;
   logic [DATA_WIDTH-1:0] dom__rdr__data;

   // Stream: a beat transfers on any rising edge where valid && ready; while valid is
   // high and ready is low, data and last hold their values.
   logic [DATA_WIDTH-1:0] rdr__xxx__data;
   logic                  rdr__xxx__valid;
   logic                  xxx__rdr__ready;
   logic                  rdr__xxx__last;

   modport master (
      output rdr__dom__address, rdr__dom__enable, rdr__dom__write,
      input  dom__rdr__data,
      output rdr__xxx__data, rdr__xxx__valid, rdr__xxx__last,
      input  xxx__rdr__ready
   );

   modport slave (
      input  rdr__dom__address, rdr__dom__enable, rdr__dom__write,
      output dom__rdr__data,
      input  rdr__xxx__data, rdr__xxx__valid, rdr__xxx__last,
      output xxx__rdr__ready
   );
endinterface

// File: rtl/dom_result_reader.sv
// Reads the OUTPUT_LENGTH-word digest back from DOM SRAM after a finish rising edge and
// streams it out. Define RDR_CHECKSUM_EN to append an XOR-of-all-words beat.
module dom_result_reader #(
   parameter int OUTPUT_LENGTH = 8,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     dut__xxx__finish,
   dom_result_reader_if.master      bus,
   output logic                     rdr__xxx__busy,
   output logic                     rdr__xxx__done,
   output logic                     rdr__xxx__overrun,
   output logic [2:0]               dbg_state_o
);
   localparam int AW = $clog2(OUTPUT_LENGTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(OUTPUT_LENGTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_CAPT = 3'd2,
      S_SEND = 3'd3,
      S_CHK  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  finish_q;
   logic                  overrun_q, overrun_d;
   logic                  trigger;
   logic                  handshake;
`ifdef RDR_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] xor_q, xor_d;
`endif

   // finish_q resets high so a level already present at reset release is not an edge.
   assign trigger   = dut__xxx__finish && !finish_q;
   assign handshake = bus.rdr__xxx__valid && bus.xxx__rdr__ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         data_q    <= '0;
         finish_q  <= 1'b1;
         overrun_q <= 1'b0;
`ifdef RDR_CHECKSUM_EN
         xor_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         finish_q  <= dut__xxx__finish;
         overrun_q <= overrun_d;
`ifdef RDR_CHECKSUM_EN
         xor_q     <= xor_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (trigger) state_d = S_READ;
         S_READ: state_d = S_CAPT;
         S_CAPT: state_d = S_SEND;
         S_SEND: begin
            if (handshake) begin
               if (idx_q != LAST_IDX) begin
                  state_d = S_READ;
               end else begin
`ifdef RDR_CHECKSUM_EN
                  state_d = S_CHK;
`else
                  state_d = S_DONE;
`endif
               end
            end
         end
`ifdef RDR_CHECKSUM_EN
         S_CHK:  if (handshake) state_d = S_DONE;
`else
         S_CHK:  state_d = S_IDLE;
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idx_d     = idx_q;
      data_d    = data_q;
      overrun_d = overrun_q;
`ifdef RDR_CHECKSUM_EN
      xor_d     = xor_q;
`endif
      // A DONE-cycle edge is dropped silently: the readout is already over.
      if (trigger && state_q != S_IDLE && state_q != S_DONE) overrun_d = 1'b1;
      case (state_q)
         S_CAPT: begin
            data_d = bus.dom__rdr__data;
`ifdef RDR_CHECKSUM_EN
            xor_d  = xor_q ^ bus.dom__rdr__data;
`endif
         end
         S_SEND: if (handshake && idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
         S_DONE: begin
            idx_d = '0;
`ifdef RDR_CHECKSUM_EN
            xor_d = '0;
`endif
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.rdr__dom__enable  = (state_q == S_READ);
      bus.rdr__dom__address = idx_q;
      bus.rdr__dom__write   = 1'b0;
      bus.rdr__xxx__valid   = (state_q == S_SEND) || (state_q == S_CHK);
`ifdef RDR_CHECKSUM_EN
      bus.rdr__xxx__data    = (state_q == S_CHK) ? xor_q : data_q;
      bus.rdr__xxx__last    = (state_q == S_CHK);
`else
      bus.rdr__xxx__data    = data_q;
      bus.rdr__xxx__last    = (state_q == S_SEND) && (idx_q == LAST_IDX);
`endif
      rdr__xxx__busy        = (state_q != S_IDLE);
      rdr__xxx__done        = (state_q == S_DONE);
      rdr__xxx__overrun     = overrun_q;
      dbg_state_o           = state_q;
   end
endmodule

// File: tb/tb_dom_result_reader.sv
// Directed bench for dom_result_reader: vector table of full readouts plus hand-written
// reset-abort and finish-at-reset sequences.
module tb_dom_result_reader;
   localparam int N  = 8;
   localparam int DW = 32;
`ifdef RDR_CHECKSUM_EN
   localparam int CHK_EXTRA = 1;
`else
   localparam int CHK_EXTRA = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       finish = 1'b0;
   logic       busy, done, overrun;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   dom_result_reader_if #(.OUTPUT_LENGTH(N), .DATA_WIDTH(DW)) bus ();

   dom_result_reader #(.OUTPUT_LENGTH(N), .DATA_WIDTH(DW)) dut (
      .clk               (clk),
      .reset             (reset),
      .dut__xxx__finish  (finish),
      .bus               (bus),
      .rdr__xxx__busy    (busy),
      .rdr__xxx__done    (done),
      .rdr__xxx__overrun (overrun),
      .dbg_state_o       (dbg_state)
   );

   // DOM SRAM model, one-cycle read latency
   logic [DW-1:0] mem [N];
   always @(posedge clk) if (bus.rdr__dom__enable) bus.dom__rdr__data <= mem[bus.rdr__dom__address];

   int          n_checks = 0;
   int          n_errors = 0;
   logic [DW:0] exp_q [$];
   int          exp_addr = 0;
   bit          any_write = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: compare every beat that will transfer on the next edge
   always @(negedge clk) begin
      if (reset) begin
         if (bus.rdr__dom__write) any_write = 1'b1;
         if (bus.rdr__dom__enable) begin
            check("dom_addr", 64'(bus.rdr__dom__address), 64'(exp_addr));
            exp_addr++;
         end
         if (bus.rdr__xxx__valid && bus.xxx__rdr__ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL beat_unexpected: got %0h expected none", bus.rdr__xxx__data);
            end else begin
               logic [DW:0] e;
               e = exp_q.pop_front();
               check("beat", {bus.rdr__xxx__last, bus.rdr__xxx__data}, 64'(e));
            end
         end
      end
   end

   typedef struct {
      bit          shift_mode;
      logic [31:0] base;
      logic [31:0] step;
      int          stall_beat;
      int          stall_len;
      int          retrig_lo;
      int          retrig_hi;
      int          exp_cycles;
      bit          exp_overrun;
   } vec_t;

   vec_t vecs [5];

   task automatic load_dom(input vec_t v);
      logic [DW-1:0] x;
      x = '0;
      for (int i = 0; i < N; i++) begin
         mem[i] = v.shift_mode ? (v.base << i) : (v.base + 32'(i) * v.step);
         x ^= mem[i];
         exp_q.push_back({(i == N - 1) && (CHK_EXTRA == 0), mem[i]});
      end
      if (CHK_EXTRA != 0) exp_q.push_back({1'b1, x});
      exp_addr  = 0;
      any_write = 1'b0;
   endtask

   task automatic arm_finish();
      @(posedge clk); #1 finish = 1'b0;
      repeat (2) @(posedge clk);
      #1 finish = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int c;
      int done_c;
      load_dom(v);
      arm_finish();
      c = -1;
      done_c = -1;
      while (done_c < 0 && c < 300) begin
         @(posedge clk);
         c++;
         #1;
         if (v.stall_len > 0 && c == 3 * v.stall_beat + 2) bus.xxx__rdr__ready = 1'b0;
         if (v.stall_len > 0 && c == 3 * v.stall_beat + 2 + v.stall_len) bus.xxx__rdr__ready = 1'b1;
         if (c == v.retrig_lo) finish = 1'b0;
         if (c == v.retrig_hi) finish = 1'b1;
         @(negedge clk);
         if (!bus.xxx__rdr__ready) begin
            check("stall_enable", 64'(bus.rdr__dom__enable), 64'd0);
            check("stall_valid", 64'(bus.rdr__xxx__valid), 64'd1);
            check("stall_data", 64'(bus.rdr__xxx__data), 64'(mem[v.stall_beat]));
         end
         if (done) done_c = c;
      end
      if (done_c < 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s timeout: got no done expected done within 300 cycles", tag);
      end else begin
         check({tag, "_cycles"}, 64'(done_c), 64'(v.exp_cycles + CHK_EXTRA));
      end
      @(negedge clk);
      check({tag, "_done_width"}, 64'(done), 64'd0);
      check({tag, "_idle_after"}, 64'(busy), 64'd0);
      check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_addr_count"}, 64'(exp_addr), 64'(N));
      check({tag, "_write"}, 64'(any_write), 64'd0);
      check({tag, "_overrun"}, 64'(overrun), 64'(v.exp_overrun));
      exp_q.delete();
      repeat (10) @(negedge clk);
      check({tag, "_no_retrigger"}, 64'(busy), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 64'(bus.rdr__xxx__valid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_enable"}, 64'(bus.rdr__dom__enable), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_overrun"}, 64'(overrun), 64'd0);
      check({tag, "_last"}, 64'(bus.rdr__xxx__last), 64'd0);
      check({tag, "_state"}, 64'(dbg_state), 64'd0);
   endtask

   initial begin
      int c;
      bus.xxx__rdr__ready = 1'b1;
      //          shift base          step          sbeat slen lo  hi  cyc ovr
      vecs[0] = '{1'b1, 32'h1,        32'h0,        -1,   0,  -1, -1, 24, 1'b0};
      vecs[1] = '{1'b0, 32'hDEAD0000, 32'h00001111,  3,   5,  -1, -1, 29, 1'b0};
      vecs[2] = '{1'b0, 32'hFFFFFFFC, 32'h1,         7,   3,  -1, -1, 27, 1'b0};
      vecs[3] = '{1'b1, 32'h3,        32'h0,         0,   1,  -1, -1, 25, 1'b0};
      vecs[4] = '{1'b1, 32'h80000001, 32'h0,        -1,   0,   6,  8, 24, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      check("reset_data", 64'(bus.rdr__xxx__data), 64'd0);
      check("reset_addr", 64'(bus.rdr__dom__address), 64'd0);
      @(negedge clk) reset = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // abort during CAPT of word 4; overrun from vec4 must clear
      load_dom(vecs[0]);
      arm_finish();
      c = -1;
      while (c < 13) begin
         @(posedge clk);
         c++;
      end
      #1;
      check("abort_state_capt", 64'(dbg_state), 64'd2);
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("abort");
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", 64'(done), 64'd0);
      end
      reset = 1'b1;
      repeat (6) @(negedge clk);
      check("held_finish_no_trigger", 64'(busy), 64'd0);
      run_vec(vecs[0], "after_abort");

      // finish high across reset release
      @(posedge clk);
      #1 finish = 1'b1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      repeat (4) @(negedge clk);
      check("finish_high_at_release", 64'(busy), 64'd0);
      run_vec(vecs[1], "after_release");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
